// File: rtl/mult_pkg.sv
// Shared definitions for the iterative MULT/MULTU unit: state encoding,
// default geometry and the step-count helper.
package mult_pkg;

  localparam int unsigned DefWidth = 32;
  localparam int unsigned DefStep  = 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } mult_state_e;

  // Number of RUN cycles needed to retire all multiplier bits.
  function automatic int unsigned calc_n(input int unsigned width, input int unsigned step);
    return width / step;
  endfunction

endpackage

// File: rtl/mult_step.sv
// One radix-2^STEP shift-add step. The accumulator is a right-shifting
// product register: the selected partial product is added into the upper
// half, then the whole 2*WIDTH value (plus carry) shifts down by STEP.
module mult_step
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned STEP  = DefStep
) (
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  input  logic [2*WIDTH-1:0] acc,
  output logic [2*WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0]   mplier_next
);

  logic [WIDTH+STEP-1:0] mcand_ext;
  logic [WIDTH+STEP-1:0] pp;
  logic [WIDTH+STEP-1:0] sum;
  logic                  unused_acc;

  assign mcand_ext = {{STEP{1'b0}}, mcand};

  // Bits shifted out of the bottom are always zero: only WIDTH shifts occur in total.
  assign unused_acc = ^acc[STEP-1:0];

  // Partial-product select for the low STEP multiplier bits, add into the upper half.
  always_comb begin
    pp = '0;
    for (int unsigned i = 0; i < STEP; i++) begin
      if (mplier[i]) begin
        pp = pp + (mcand_ext << i);
      end
    end
    // Upper half < 2^WIDTH and pp < 2^(WIDTH+STEP) - 2^WIDTH, so the sum cannot overflow.
    sum         = {{STEP{1'b0}}, acc[2*WIDTH-1:WIDTH]} + pp;
    acc_next    = {sum, acc[WIDTH-1:STEP]};
    mplier_next = mplier >> STEP;
  end

endmodule

// File: rtl/mult_unit.sv
// Iterative MULT/MULTU unit for the EX stage. Owns HI/LO, reports busy to
// the hazard unit and honours its flush through abort. Signed operands are
// multiplied as magnitudes and the 2*WIDTH product is negated at the end.
module mult_unit
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned STEP  = DefStep
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             abort,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned N    = calc_n(WIDTH, STEP);
  localparam int unsigned CntW = $clog2(N + 1);

  mult_state_e        state_q;
  logic [CntW-1:0]    cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic               neg_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   mplier_nxt;

  // Unsigned magnitude; the most negative value maps onto itself.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

  mult_step #(
    .WIDTH(WIDTH),
    .STEP (STEP)
  ) u_step (
    .mcand      (mcand_q),
    .mplier     (mplier_q),
    .acc        (acc_q),
    .acc_next   (acc_nxt),
    .mplier_next(mplier_nxt)
  );

  // Control FSM, datapath registers and HI/LO; all outputs are registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          // abort > start > MTHI/MTLO
          if (abort) begin
            busy_q <= 1'b0;
          end else if (start) begin
            mcand_q  <= is_signed ? mag(srca) : srca;
            mplier_q <= is_signed ? mag(srcb) : srcb;
            neg_q    <= is_signed & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
            acc_q    <= '0;
            cnt_q    <= CntW'(N);
            busy_q   <= 1'b1;
            state_q  <= StRun;
          end else begin
            if (hi_we) hi_q <= wdata;
            if (lo_we) lo_q <= wdata;
          end
        end
        StRun: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            acc_q    <= acc_nxt;
            mplier_q <= mplier_nxt;
            cnt_q    <= cnt_q - 1'b1;
            if (cnt_q == CntW'(1)) begin
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            {hi_q, lo_q} <= neg_q ? (~acc_q + 1'b1) : acc_q;
            done_q       <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/mult_unit.md
Name: mult_unit

Overview:
- Iterative multi-cycle MULT/MULTU execution unit in the EX stage of the MIPS pipeline.
- Owns the HI/LO registers and produces the `busy` signal. `busy` drives the hazard unit's `multiply` input.
- The hazard unit answers with stall/flush. `abort` carries that flush back so a squashed multiply is cancelled.

Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH bits each.
- STEP, 1, multiplier bits retired per cycle. Legal values are 1, 2 and 4, and STEP must divide WIDTH.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-low reset; 0 resets the unit.
- start  input  1  one-cycle request to begin a multiply; operands are valid in the same cycle.
- is_signed  input  1  1 = MULT, 0 = MULTU; sampled with start.
- srca  input  WIDTH  multiplicand.
- srcb  input  WIDTH  multiplier.
- abort  input  1  flush from the hazard unit; cancels an in-flight operation.
- hi_we  input  1  MTHI write enable.
- lo_we  input  1  MTLO write enable.
- wdata  input  WIDTH  MTHI/MTLO data.
- busy  output  1  registered; high while an operation is in flight; connects to the hazard unit's multiply input.
- done  output  1  registered one-cycle pulse when HI/LO have just been updated by a product.
- hi  output  WIDTH  HI register (MFHI source).
- lo  output  WIDTH  LO register (MFLO source).

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE.
  - busy = 0, done = 0, hi = 0, lo = 0; counter and accumulator cleared.
- States: IDLE, RUN, DONE. N = WIDTH/STEP.
- IDLE:
  - If start = 1 and abort = 0, at edge E0:
    - Latch |srca| and |srcb| when is_signed = 1; latch raw operands when is_signed = 0.
    - Latch neg = is_signed & (srca[MSB] ^ srcb[MSB]).
    - Clear the 2*WIDTH accumulator, set counter = N, go to RUN.
  - The magnitude of the most negative value is taken as an unsigned WIDTH-bit value (0x80000000 -> 0x80000000).
- RUN:
  - Each edge performs one radix-2^STEP shift-add step on the accumulator and decrements the counter.
  - The edge at which counter = 1 moves to DONE.
- DONE, one cycle:
  - At the next edge, {hi, lo} = neg ? two's-complement(acc) : acc.
  - done is set to 1 for exactly the following cycle; state goes to IDLE.
- Latency:
  - busy = 1 for cycles E0+1 through E0+N+1, i.e. N+1 cycles (33 by default).
  - New hi/lo are visible after edge E0+N+1, in the same cycle done = 1.
- busy is purely registered, with no combinational path from start.
- start while busy = 1: ignored (the pipeline guarantees it does not occur).
- abort:
  - In RUN or DONE: the next edge goes to IDLE; hi and lo unchanged; done stays 0.
  - In IDLE with start = 1: start is dropped.
  - abort has highest priority.
- hi_we/lo_we:
  - Honoured only in IDLE, and only when start = 0 in the same cycle; the write is visible after the edge.
  - Ignored when start = 1 or busy = 1.
  - hi_we and lo_we together both write wdata.
- Priority in IDLE: abort > start > hi_we/lo_we.
- done and busy are never both 0 while in DONE. done falls back to 0 the cycle after its pulse.
- Reset asserted mid-operation forces IDLE immediately; HI/LO clear to 0.
- Arithmetic:
  - Accumulator is 2*WIDTH bits, unsigned.
  - The sign fix is a 2*WIDTH two's-complement negate.
  - All products are exact; no overflow is possible.

Decomposition:
- Shared package/include mult_pkg holds:
  - state encodings: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  - default WIDTH and STEP;
  - the function computing N.
- One combinational sub-module, mult_step, computes one radix-2^STEP step: partial-product select and add, and shift of the accumulator/multiplier. It is instantiated once.

Test Plan:
- Unsigned 7 * 6, start for one cycle: busy high 33 cycles, then hi = 0x00000000, lo = 0x0000002A, done pulses once.
- MULTU 0xFFFFFFFF * 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001. The same operands with MULT (-1 * -1) -> hi = 0, lo = 1.
- MULT -3 (0xFFFFFFFD) * 5 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFF1. MULT 0x80000000 * 0x80000000 -> hi = 0x40000000, lo = 0.
- Preload hi = 0x11111111 via MTHI, start 9 * 9, assert abort at cycle 10 of RUN:
  - busy drops the next cycle, done never pulses, hi stays 0x11111111.
  - A new 9 * 9 then completes with lo = 0x51.
- MTLO with wdata = 0xA5A5A5A5 asserted during busy is ignored. Start and lo_we asserted in the same cycle: start is accepted and lo_we is ignored.
- Assert reset = 0 mid-RUN:
  - busy = 0, done = 0, hi = lo = 0 immediately, with no clock edge needed.
  - Deassert reset, then repeat 7 * 6: correct result after 33 cycles.
- Repeat all cases with STEP = 2 and STEP = 4: busy lasts 17 and 9 cycles respectively, with identical hi/lo results.
